multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control FSM for the RV32I datapath subset (R-type ALU, I-type ALU, LW, SW, BEQ/BNE). It consumes the opcode/funct3/funct7 fields produced by the instruction field decoder from the instruction register. It sequences fetch, decode, execute, memory and write-back, handshaking with a shared instruction/data memory through `mem_ready`. It also flags illegal encodings and counts retired instructions.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `opcode`  in  7  instruction[6:0] from decoder
- `funct3`  in  3  instruction[14:12]
- `funct7`  in  7  instruction[31:25]
- `mem_ready`  in  1  memory completes current read/write this cycle
- `ir_write`, `pc_write`, `pc_write_cond`  out  1 each  IR load, unconditional PC load, branch-qualified PC load
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result
- `mem_read`, `mem_write`  out  1 each  memory strobes
- `reg_write`, `mem_to_reg`  out  1 each  regfile write enable, write-data select (1 = memory)
- `alu_src_a`  out  1  0 = PC, 1 = rs1
- `alu_src_b`  out  2  00 rs2, 01 const 4, 10 imm, 11 branch offset
- `alu_op`  out  2  00 add, 01 subtract/compare, 10 R-type decode, 11 I-type decode
- `branch_ne`  out  1  = funct3[0] in BRANCH, else 0
- `illegal`  out  1  sticky illegal-instruction flag
- `state`  out  4  current state encoding (debug)
- `instret`  out  32  retired-instruction counter

## Operation
- Encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=10; 11–15 unreachable, go to TRAP.
- All outputs are 0 unless listed for the current state.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - When mem_ready=1: also ir_write=1 and pc_write=1 (Mealy), then go to DECODE.
  - When mem_ready=0: stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 0110011 → EXEC_R if funct7 ∈ {0000000, 0100000}, else TRAP.
  - 0010011 → EXEC_I.
  - 0000011 or 0100011 → ADDR.
  - 1100011 → BRANCH if funct3 ∈ {000, 001}, else TRAP.
  - Any other opcode → TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11 → WB_ALU.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_RD (load) or MEM_WR (store). Opcode is re-evaluated here; the IR is stable.
- MEM_RD: mem_read=1, iord=1; go to WB_MEM on mem_ready, else hold.
- MEM_WR: mem_write=1, iord=1; go to FETCH on mem_ready (retire), else hold.
- WB_ALU: reg_write=1, mem_to_reg=0 → FETCH (retire).
- WB_MEM: reg_write=1, mem_to_reg=1 → FETCH (retire).
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, branch_ne=funct3[0] → FETCH (retire).
- TRAP: illegal=1; all strobes 0; stays in TRAP until reset.
- rd = x0 is not special-cased; reg_write still asserts and the register file discards the write.
- instret increments by 1 on the clock edge of each retire transition. It wraps 0xFFFFFFFF → 0.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Timing
- Reset (synchronous, checked each rising edge, overrides everything): state=FETCH, instret=0, illegal=0.
  - First cycle after reset: mem_read=1, iord=0; all other strobes 0.
- Reset asserted mid-instruction (including during a memory wait) abandons the instruction; no retire, no increment.
- State and counters are registered. Outputs are combinational from state; only ir_write and pc_write in FETCH also depend on mem_ready.
- Cycles per instruction with zero-wait memory: R/I-ALU 4, LW 5, SW 4, BEQ/BNE 3.
- Each cycle of mem_ready=0 in a memory state adds exactly one cycle. Strobes stay asserted and stable throughout the wait.
- In FETCH, ir_write and pc_write assert for exactly one cycle per instruction.

## Test plan
- Reset, then `add` (opcode 0110011, funct7 0) with mem_ready held 1 → states 0,1,2,7,0; reg_write=1 only in cycle 4; instret=1.
- `lw` with mem_ready low for 3 cycles in MEM_RD → mem_read=iord=1 held 4 cycles; WB_MEM with mem_to_reg=1; instret +1; total 8 cycles.
- `bne` (funct3 001) → BRANCH with pc_write_cond=1, branch_ne=1, alu_op=01. `beq` gives branch_ne=0.
- Illegal cases: opcode 1111111, R-type with funct7 0000001, and branch funct3 100 → TRAP; illegal=1 stays set with mem_ready toggling; instret frozen; reset returns to FETCH with illegal=0.
- Reset asserted during a MEM_WR wait → next cycle state=0, mem_write=0, instret unchanged from 0 after reset.
- Preload instret near the top (or run 2^32 retires in a fast model) → 0xFFFFFFFF wraps to 0 on the next retire.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for an RV32I subset: sequences fetch/decode/execute/memory/write-back
// over a shared memory, traps illegal encodings and counts retired instructions.
module multicycle_control (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic        i_mem_ready,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_pc_write_cond,
  output logic        o_iord,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_reg_write,
  output logic        o_mem_to_reg,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_alu_op,
  output logic        o_branch_ne,
  output logic        o_illegal,
  output logic [3:0]  o_state,
  output logic [31:0] o_instret
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StAddr   = 4'd4,
    StMemRd  = 4'd5,
    StMemWr  = 4'd6,
    StWbAlu  = 4'd7,
    StWbMem  = 4'd8,
    StBranch = 4'd9,
    StTrap   = 4'd10
  } state_e;

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_instret;
  logic        w_retire;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StFetch;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      StFetch: if (i_mem_ready) w_next = StDecode;
      StDecode: begin
        case (i_opcode)
          OpR:      w_next = (i_funct7 == 7'b0000000 || i_funct7 == 7'b0100000) ? StExecR : StTrap;
          OpI:      w_next = StExecI;
          OpLoad,
          OpStore:  w_next = StAddr;
          OpBranch: w_next = (i_funct3[2:1] == 2'b00) ? StBranch : StTrap;
          default:  w_next = StTrap;
        endcase
      end
      StExecR, StExecI: w_next = StWbAlu;
      // IR is stable, so the load/store split is resolved again here
      StAddr: begin
        if (i_opcode == OpLoad)       w_next = StMemRd;
        else if (i_opcode == OpStore) w_next = StMemWr;
        else                          w_next = StTrap;
      end
      StMemRd: if (i_mem_ready) w_next = StWbMem;
      StMemWr: begin
        if (i_mem_ready) begin
          w_next   = StFetch;
          w_retire = 1'b1;
        end
      end
      StWbAlu, StWbMem, StBranch: begin
        w_next   = StFetch;
        w_retire = 1'b1;
      end
      StTrap:  w_next = StTrap;
      default: w_next = StTrap;
    endcase
  end

  always_comb begin
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_reg_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = 2'b00;
    o_alu_op        = 2'b00;
    o_branch_ne     = 1'b0;
    o_illegal       = 1'b0;
    case (r_state)
      StFetch: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      StDecode: o_alu_src_b = 2'b11;
      StExecR: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
      end
      StExecI: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_alu_op    = 2'b11;
      end
      StAddr: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      StMemRd: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      StMemWr: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      StWbAlu: o_reg_write = 1'b1;
      StWbMem: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      StBranch: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = 2'b01;
        o_pc_write_cond = 1'b1;
        o_branch_ne     = i_funct3[0];
      end
      StTrap:  o_illegal = 1'b1;
      default: ;
    endcase
  end

  assign o_state   = r_state;
  assign o_instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors and retire counting.
module tb_multicycle_control;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic        i_mem_ready;
  logic        o_ir_write, o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write;
  logic        o_reg_write, o_mem_to_reg, o_alu_src_a, o_branch_ne, o_illegal;
  logic [1:0]  o_alu_src_b, o_alu_op;
  logic [3:0]  o_state;
  logic [31:0] o_instret;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7(i_funct7), .i_mem_ready(i_mem_ready), .o_ir_write(o_ir_write),
    .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond), .o_iord(o_iord),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_branch_ne(o_branch_ne), .o_illegal(o_illegal),
    .o_state(o_state), .o_instret(o_instret)
  );

  always #5 i_clk = ~i_clk;

  // {ir_write, pc_write, pc_write_cond, iord, mem_read, mem_write, reg_write, mem_to_reg,
  //  alu_src_a, alu_src_b, alu_op, branch_ne, illegal, state}
  logic [18:0] w_obs;
  assign w_obs = {o_ir_write, o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
                  o_reg_write, o_mem_to_reg, o_alu_src_a, o_alu_src_b, o_alu_op, o_branch_ne,
                  o_illegal, o_state};

  localparam logic [18:0] F0   = 19'b0_0_0_0_1_0_0_0_0_01_00_0_0_0000;
  localparam logic [18:0] F1   = 19'b1_1_0_0_1_0_0_0_0_01_00_0_0_0000;
  localparam logic [18:0] DEC  = 19'b0_0_0_0_0_0_0_0_0_11_00_0_0_0001;
  localparam logic [18:0] EXR  = 19'b0_0_0_0_0_0_0_0_1_00_10_0_0_0010;
  localparam logic [18:0] EXI  = 19'b0_0_0_0_0_0_0_0_1_10_11_0_0_0011;
  localparam logic [18:0] ADR  = 19'b0_0_0_0_0_0_0_0_1_10_00_0_0_0100;
  localparam logic [18:0] MRD  = 19'b0_0_0_1_1_0_0_0_0_00_00_0_0_0101;
  localparam logic [18:0] MWR  = 19'b0_0_0_1_0_1_0_0_0_00_00_0_0_0110;
  localparam logic [18:0] WBA  = 19'b0_0_0_0_0_0_1_0_0_00_00_0_0_0111;
  localparam logic [18:0] WBM  = 19'b0_0_0_0_0_0_1_1_0_00_00_0_0_1000;
  localparam logic [18:0] BRE  = 19'b0_0_1_0_0_0_0_0_1_00_01_0_0_1001;
  localparam logic [18:0] BRN  = 19'b0_0_1_0_0_0_0_0_1_00_01_1_0_1001;
  localparam logic [18:0] TRP  = 19'b0_0_0_0_0_0_0_0_0_00_00_0_1_1010;

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    i_opcode = op;
    i_funct3 = f3;
    i_funct7 = f7;
  endtask

  task automatic test_reset();
    i_mem_ready = 1'b0;
    do_reset();
    #1;
    n_tests++;
    if (w_obs !== F0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want %b", w_obs, F0);
    end
    n_tests++;
    if (o_instret !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_instret: got %0d want 0", o_instret);
    end
    @(posedge i_clk); #1;
  endtask

  // Expects to start in FETCH; runs one instruction cycle by cycle, then checks instret.
  task automatic test_add();
    logic [18:0] exp [4];
    exp = '{F1, DEC, EXR, WBA};
    do_reset();
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      i_mem_ready = 1'b1;
      #1;
      n_tests++;
      if (w_obs !== exp[i]) begin
        n_fail++;
        $display("FAIL add_cyc%0d: got %b want %b", i, w_obs, exp[i]);
      end
      @(posedge i_clk); #1;
    end
    #1;
    n_tests++;
    if (o_state !== 4'd0 || o_instret !== 32'd1) begin
      n_fail++;
      $display("FAIL add_retire: state %0d instret %0d want 0 1", o_state, o_instret);
    end
  endtask

  task automatic test_lw();
    logic [18:0] exp [8];
    logic        rdy [8];
    exp = '{F1, DEC, ADR, MRD, MRD, MRD, MRD, WBM};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    for (int i = 0; i < 8; i++) begin
      i_mem_ready = rdy[i];
      #1;
      n_tests++;
      if (w_obs !== exp[i]) begin
        n_fail++;
        $display("FAIL lw_cyc%0d: got %b want %b", i, w_obs, exp[i]);
      end
      @(posedge i_clk); #1;
    end
    n_tests++;
    if (o_state !== 4'd0 || o_instret !== 32'd2) begin
      n_fail++;
      $display("FAIL lw_retire: state %0d instret %0d want 0 2", o_state, o_instret);
    end
  endtask

  task automatic test_sw();
    logic [18:0] exp [6];
    logic        rdy [6];
    exp = '{F0, F1, DEC, ADR, MWR, MWR};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    for (int i = 0; i < 6; i++) begin
      i_mem_ready = rdy[i];
      #1;
      n_tests++;
      if (w_obs !== exp[i]) begin
        n_fail++;
        $display("FAIL sw_cyc%0d: got %b want %b", i, w_obs, exp[i]);
      end
      @(posedge i_clk); #1;
    end
    n_tests++;
    if (o_state !== 4'd0 || o_instret !== 32'd3) begin
      n_fail++;
      $display("FAIL sw_retire: state %0d instret %0d want 0 3", o_state, o_instret);
    end
  endtask

  // bne, beq, then addi, back to back; instret continues from 3
  task automatic test_back_to_back();
    logic [6:0]  ops [3];
    logic [2:0]  f3s [3];
    logic [18:0] exp [3][4];
    int          len [3];
    ops = '{7'b1100011, 7'b1100011, 7'b0010011};
    f3s = '{3'b001, 3'b000, 3'b000};
    exp = '{'{F1, DEC, BRN, F0}, '{F1, DEC, BRE, F0}, '{F1, DEC, EXI, WBA}};
    len = '{3, 3, 4};
    for (int k = 0; k < 3; k++) begin
      set_instr(ops[k], f3s[k], 7'b0000000);
      for (int i = 0; i < len[k]; i++) begin
        i_mem_ready = 1'b1;
        #1;
        n_tests++;
        if (w_obs !== exp[k][i]) begin
          n_fail++;
          $display("FAIL b2b%0d_cyc%0d: got %b want %b", k, i, w_obs, exp[k][i]);
        end
        @(posedge i_clk); #1;
      end
      n_tests++;
      if (o_instret !== 32'd4 + 32'(k)) begin
        n_fail++;
        $display("FAIL b2b%0d_instret: got %0d want %0d", k, o_instret, 4 + k);
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [3];
    logic [2:0] f3s [3];
    logic [6:0] f7s [3];
    ops = '{7'b1111111, 7'b0110011, 7'b1100011};
    f3s = '{3'b000, 3'b000, 3'b100};
    f7s = '{7'b0000000, 7'b0000001, 7'b0000000};
    for (int k = 0; k < 3; k++) begin
      i_mem_ready = 1'b1;
      do_reset();
      set_instr(ops[k], f3s[k], f7s[k]);
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      for (int i = 0; i < 4; i++) begin
        i_mem_ready = i[0];
        #1;
        n_tests++;
        if (w_obs !== TRP || o_instret !== 32'd0) begin
          n_fail++;
          $display("FAIL illegal%0d_cyc%0d: got %b/%0d want %b/0", k, i, w_obs, o_instret,
                   TRP);
        end
        @(posedge i_clk); #1;
      end
      i_mem_ready = 1'b0;
      do_reset();
      #1;
      n_tests++;
      if (w_obs !== F0) begin
        n_fail++;
        $display("FAIL illegal%0d_clear: got %b want %b", k, w_obs, F0);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    i_mem_ready = 1'b1;
    do_reset();
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
    end
    i_mem_ready = 1'b0;
    @(posedge i_clk); #1;
    #1;
    n_tests++;
    if (w_obs !== MWR) begin
      n_fail++;
      $display("FAIL midrst_wait: got %b want %b", w_obs, MWR);
    end
    do_reset();
    #1;
    n_tests++;
    if (w_obs !== F0 || o_instret !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_after: got %b/%0d want %b/0", w_obs, o_instret, F0);
    end
  endtask

  task automatic test_wrap();
    i_mem_ready = 1'b1;
    do_reset();
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    #1;
    n_tests++;
    if (o_instret !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h want ffffffff", o_instret);
    end
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
    end
    n_tests++;
    if (o_instret !== 32'd0 || o_state !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap: instret %h state %0d want 00000000 0", o_instret, o_state);
    end
  endtask

  initial begin
    i_reset     = 1'b1;
    i_mem_ready = 1'b0;
    i_opcode    = 7'd0;
    i_funct3    = 3'd0;
    i_funct7    = 7'd0;
    #2;
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_reset_mid_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
